add_serial_4bit: RTL and testbench

//   Bit-serial two's-complement adder, the complement of the parallel subtractor.

---
 rtl/add_serial_4bit_if.sv | 28 ++
 rtl/add_serial_4bit.sv | 143 ++++++++++++++
 tb/tb_add_serial_4bit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/add_serial_4bit_if.sv
// Valid/ready operand and result channels of the bit-serial adder.
`default_nettype none

interface add_serial_4bit_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, carry, overflow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, carry, overflow
  );
endinterface

`default_nettype wire

// File: rtl/add_serial_4bit.sv
// add_serial_4bit: LSB-first bit-serial two's-complement adder, one full-adder cell.
// Optional saturation of overflowed sums: define ADD_SERIAL_SAT_EN. Rev 1.0
`default_nettype none

module add_serial_4bit #(
  parameter int WIDTH = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  add_serial_4bit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             cy_q, cy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic             bit_s;
  logic             bit_c;
  logic             ovf_w;
  logic [WIDTH-1:0] sum_final;

  assign bit_s = a_sh_q[0] ^ b_sh_q[0] ^ cy_q;
  assign bit_c = (a_sh_q[0] & b_sh_q[0]) | (cy_q & (a_sh_q[0] ^ b_sh_q[0]));

  // Operand MSBs are kept aside because the shift registers are consumed by then.
  assign ovf_w = (a_msb_q == b_msb_q) && (sum_sh_q[WIDTH-1] != a_msb_q);

`ifdef ADD_SERIAL_SAT_EN
  assign sum_final = ovf_w ? {a_msb_q, {(WIDTH-1){~a_msb_q}}} : sum_sh_q;
`else
  assign sum_final = sum_sh_q;
`endif

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    sum_sh_d    = sum_sh_q;
    cy_d        = cy_q;
    cnt_d       = cnt_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = bus.b[WIDTH-1];
          cy_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_sh_d = {bit_s, sum_sh_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cy_d     = bit_c;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // First DONE cycle publishes the result; handshake is only possible after.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          sum_d       = sum_final;
          carry_d     = cy_q;
          ovf_d       = ovf_w;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      cy_q        <= 1'b0;
      cnt_q       <= '0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_sh_q    <= sum_sh_d;
      cy_q        <= cy_d;
      cnt_q       <= cnt_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_add_serial_4bit.sv
// Randomized scoreboard bench for add_serial_4bit against an arithmetic reference model.
`default_nettype none

module tb_add_serial_4bit;
  localparam int WIDTH = 4;
  localparam int MAXP  = (1 << (WIDTH - 1)) - 1;
  localparam int MINN  = -(1 << (WIDTH - 1));

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  add_serial_4bit_if #(.WIDTH(WIDTH)) bus ();
  add_serial_4bit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec      = 0;
  int   n_bad      = 0;
  int   cyc        = 0;
  int   accept_cyc = 0;
  bit   prev_ov    = 1'b0;
  bit   rand_done  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t r;
    int   s;
    int   u;
    s = int'($signed(a)) + int'($signed(b));
    u = int'(a) + int'(b);
    r.sum   = u[WIDTH-1:0];
    r.carry = (u >= (1 << WIDTH));
    r.ovf   = (s > MAXP) || (s < MINN);
`ifdef ADD_SERIAL_SAT_EN
    if (r.ovf) begin
      r.sum = (s > MAXP) ? WIDTH'(MAXP) : WIDTH'(MINN);
    end
`endif
    return r;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Monitor: latency on each rising out_valid, scoreboard pop on each handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (bus.out_valid && !prev_ov) begin
        chk("latency", cyc - accept_cyc, WIDTH + 1);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_result: got sum=%0h with empty queue", bus.sum);
        end else begin
          mon_e = exp_q.pop_front();
          chk("result", int'({bus.sum, bus.carry, bus.overflow}), int'(mon_e));
        end
      end
      prev_ov = bus.out_valid;
    end
  end

  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int t = 0;
    while (!bus.in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    @(posedge clk); #1;
    accept_cyc = cyc;
    exp_q.push_back(model(a, b));
    bus.in_valid = 1'b0;
    bus.a        = WIDTH'($urandom);
    bus.b        = WIDTH'($urandom);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   t;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_in_ready", int'(bus.in_ready), 1);
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_outputs", int'({bus.sum, bus.carry, bus.overflow}), 0);

    // Directed corner cases: plain, unsigned carry, positive and negative overflow.
    do_op(4'd3, 4'd4);   wait_drain();
    do_op(4'hF, 4'h1);   wait_drain();
    do_op(4'd7, 4'd1);   wait_drain();
    do_op(4'h8, 4'hF);   wait_drain();

    // Backpressure held for six cycles in DONE.
    bus.out_ready = 1'b0;
    e = model(4'd5, 4'd2);
    do_op(4'd5, 4'd2);
    t = 0;
    while (!bus.out_valid && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp_hold", int'({bus.out_valid, bus.in_ready, bus.sum}), int'({1'b1, 1'b0, e.sum}));
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", int'({bus.out_valid, bus.in_ready}), int'(2'b01));

    // Asynchronous reset while an operation is in flight.
    do_op(4'd5, 4'd6);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("abort_ctrl", int'({bus.in_ready, bus.out_valid}), int'(2'b10));
    chk("abort_outputs", int'({bus.sum, bus.carry, bus.overflow}), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(4'd2, 4'd2);
    wait_drain();

    // Random operands, random issue gaps, random downstream stalls.
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
          do_op(WIDTH'($urandom), WIDTH'($urandom));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    wait_drain();
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
